// File: rtl/exception_unit_pkg.sv
// Shared types and encodings for the exception unit: FSM states, PC-source selects, cause codes.
package exc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } exc_state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_ELR = 2'b10;

    localparam logic [3:0] EXC_NONE   = 4'b0000;
    localparam logic [3:0] EXC_EXTIRQ = 4'b0001;
    localparam logic [3:0] EXC_BADOP  = 4'b0010;

endpackage

// File: rtl/exception_unit_if.sv
// Controller/datapath-facing bundle of the exception unit. exc_count exists only with EXC_CNT_EN.
interface exception_unit_if #(
    parameter int N = 64
);
    logic         ExtIRQ;
    logic         Exc;
    logic         ERet;
    logic [3:0]   EStatus;
    logic [N-1:0] PC;
    logic         irq_req;
    logic         ExcAck;
    logic         ExtIAck;
    logic [1:0]   pc_sel;
    logic [N-1:0] vec_addr;
    logic [N-1:0] ELR;
    logic [3:0]   ESR;
    logic         dbl_fault;
`ifdef EXC_CNT_EN
    logic [15:0]  exc_count;
`endif

    modport master (
        output ExtIRQ, Exc, ERet, EStatus, PC,
        input  irq_req, ExcAck, ExtIAck, pc_sel, vec_addr, ELR, ESR, dbl_fault
`ifdef EXC_CNT_EN
        , input exc_count
`endif
    );

    modport slave (
        input  ExtIRQ, Exc, ERet, EStatus, PC,
        output irq_req, ExcAck, ExtIAck, pc_sel, vec_addr, ELR, ESR, dbl_fault
`ifdef EXC_CNT_EN
        , output exc_count
`endif
    );

endinterface

// File: rtl/exception_unit_irq_sync.sv
// External interrupt synchroniser plus "already taken" tracking so a held level is serviced once.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_irq,
    input  logic take,
    output logic irq_sync,
    output logic irq_seen
);

    logic [SYNC_STAGES-1:0] chain;

    // A taken interrupt stays masked until the synchronised level has dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chain    <= '0;
            irq_seen <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], ext_irq};
            if (take)
                irq_seen <= 1'b1;
            else if (!chain[SYNC_STAGES-1])
                irq_seen <= 1'b0;
        end
    end

    assign irq_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/exception_unit.sv
// Exception/interrupt unit: holds ELR/ESR, runs ExcAck/ExtIAck and selects the next PC source.
// Optional accepted-exception counter is built when EXC_CNT_EN is defined.
module exception_unit
    import exc_pkg::*;
#(
    parameter int             N           = 64,
    parameter logic [N-1:0]   VEC_ADDR    = N'(8'hD8),
    parameter int             SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    exception_unit_if.slave bus
);

    exc_state_t   state, state_nxt;
    logic         exc_ack;
    logic [1:0]   pc_sel;
    logic         take_irq;
    logic         irq_sync_q;
    logic         irq_seen_q;
    logic [N-1:0] elr_q;
    logic [3:0]   esr_q;
    logic         ext_iack_q;
    logic         dbl_fault_q;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .ext_irq  (bus.ExtIRQ),
        .take     (take_irq),
        .irq_sync (irq_sync_q),
        .irq_seen (irq_seen_q)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Exc has priority in IDLE; ERet has priority in HANDLER.
    always_comb begin
        state_nxt = state;
        exc_ack   = 1'b0;
        pc_sel    = PCSEL_SEQ;
        case (state)
            IDLE: begin
                if (bus.Exc) begin
                    exc_ack   = 1'b1;
                    pc_sel    = PCSEL_VEC;
                    state_nxt = HANDLER;
                end
            end
            HANDLER: begin
                if (bus.ERet) begin
                    pc_sel    = PCSEL_ELR;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign take_irq = exc_ack && (bus.EStatus == EXC_EXTIRQ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            elr_q       <= '0;
            esr_q       <= EXC_NONE;
            ext_iack_q  <= 1'b0;
            dbl_fault_q <= 1'b0;
        end else begin
            if (exc_ack) begin
                elr_q <= bus.PC;
                esr_q <= bus.EStatus;
            end
            ext_iack_q <= take_irq;
            if (state == HANDLER && bus.Exc)
                dbl_fault_q <= 1'b1;
        end
    end

`ifdef EXC_CNT_EN
    logic [15:0] exc_count_q;

    always_ff @(posedge clk) begin
        if (!reset)
            exc_count_q <= '0;
        else if (exc_ack && exc_count_q != 16'hFFFF)
            exc_count_q <= exc_count_q + 16'd1;
    end

    assign bus.exc_count = exc_count_q;
`endif

    assign bus.irq_req   = irq_sync_q && !irq_seen_q && (state == IDLE);
    assign bus.ExcAck    = exc_ack;
    assign bus.ExtIAck   = ext_iack_q;
    assign bus.pc_sel    = pc_sel;
    assign bus.vec_addr  = VEC_ADDR;
    assign bus.ELR       = elr_q;
    assign bus.ESR       = esr_q;
    assign bus.dbl_fault = dbl_fault_q;

endmodule
